// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter in front of a 4:1 bit mux: one-hot grant, mux select, bounded burst hold.
// Optional macro ARB_LOCK_EN adds a lock input that lets the owner suppress the hold timeout.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit               HOLD_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
  logic [1:0]       ptr, ptr_nx;
  logic [3:0]       grant_nx;
  logic [1:0]       select_nx;
  logic [2:0]       win_idle, win_rel;
  logic             timeout, release_now;

  // Returns {found, index}: first requester after p, wrapping, p itself checked last.
  function automatic logic [2:0] find_winner(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = p + k[1:0];
      if (r[idx] && !res[2]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign win_idle = find_winner(req, ptr);
  assign win_rel  = find_winner(req, select);

`ifdef ARB_LOCK_EN
  assign timeout = HOLD_EN && (hold_cnt >= LAST) && !(lock && req[select]);
`else
  assign timeout = HOLD_EN && (hold_cnt == LAST);
`endif

  assign release_now = !req[select] || timeout;

  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    select_nx   = select;
    hold_cnt_nx = hold_cnt;
    ptr_nx      = ptr;
    case (state)
      IDLE: begin
        if (win_idle[2]) begin
          state_nx    = GRANT;
          grant_nx    = 4'b0001 << win_idle[1:0];
          select_nx   = win_idle[1:0];
          hold_cnt_nx = '0;
        end
      end
      GRANT: begin
        if (!release_now) begin
          if (hold_cnt != {CNT_W{1'b1}}) hold_cnt_nx = hold_cnt + CNT_W'(1);
        end else begin
          ptr_nx      = select;
          hold_cnt_nx = '0;
          if (win_rel[2]) begin
            grant_nx  = 4'b0001 << win_rel[1:0];
            select_nx = win_rel[1:0];
          end else begin
            state_nx = IDLE;
            grant_nx = 4'b0000;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = 4'b0000;
      end
    endcase
  end

  // Pointer resets to 3 so requester 0 wins the first search.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      select   <= 2'b00;
      hold_cnt <= '0;
      ptr      <= 2'd3;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      select   <= select_nx;
      hold_cnt <= hold_cnt_nx;
      ptr      <= ptr_nx;
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: vector table plus multi-cycle sequences via a scoreboard queue.
module tb_mux4_rr_arbiter;

`ifdef ARB_LOCK_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] select;
  logic       busy;
`ifdef ARB_LOCK_EN
  logic       lock;
`endif

  mux4_rr_arbiter #(.MAX_HOLD(HOLD), .CNT_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
`ifdef ARB_LOCK_EN
    .lock   (lock),
`endif
    .grant  (grant),
    .select (select),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] select;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] select;
    logic       busy;
    string      name;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void compare(input logic [3:0] g, input logic [1:0] s, input logic b,
                                  input string nm);
    n_checks++;
    if (grant !== g || select !== s || busy !== b) begin
      n_fail++;
      $display("FAIL %s: got grant=%b select=%0d busy=%b, want grant=%b select=%0d busy=%b",
               nm, grant, select, busy, g, s, b);
    end
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic apply(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                       input logic b, input string nm);
    exp_t e;
    req = r;
    sb.push_back('{g, s, b, nm});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      compare(e.grant, e.select, e.busy, e.name);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] r);
    reset = 1'b1;
    req   = r;
    #1;
    compare(4'b0000, 2'd0, 1'b0, "reset_state");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] own;
    vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[2]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[4]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[5]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[6]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[7]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    vecs[8]  = '{4'b0000, 4'b0000, 2'd3, 1'b0};
    vecs[9]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[10] = '{4'b0110, 4'b0010, 2'd1, 1'b1};
    vecs[11] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[12] = '{4'b0000, 4'b0000, 2'd2, 1'b0};

    reset = 1'b0;
    req   = 4'b0000;
`ifdef ARB_LOCK_EN
    lock  = 1'b0;
`endif
    @(negedge clk);
    do_reset(4'b0000);

    for (int i = 0; i < 13; i++)
      apply(vecs[i].req, vecs[i].grant, vecs[i].select, vecs[i].busy, $sformatf("vec%0d", i));

    // All four requesting: bursts of exactly HOLD cycles rotating 0,1,2,3,0.
    do_reset(4'b0000);
    for (int k = 0; k < 5 * HOLD; k++) begin
      own = 2'((k / HOLD) % 4);
      apply(4'b1111, 4'b0001 << own, own, 1'b1, $sformatf("rotate_c%0d", k));
    end

    // Sole requester is re-granted at each timeout without a bubble.
    do_reset(4'b0000);
    for (int k = 0; k < 20; k++)
      apply(4'b0100, 4'b0100, 2'd2, 1'b1, $sformatf("sole_c%0d", k));

    // Reset mid-grant at owner 2, then requester 0 wins first.
    reset = 1'b1;
    req   = 4'b0101;
    #1;
    compare(4'b0000, 2'd0, 1'b0, "reset_midgrant");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < HOLD; k++)
      apply(4'b0101, 4'b0001, 2'd0, 1'b1, $sformatf("after_reset_c%0d", k));
    apply(4'b0101, 4'b0100, 2'd2, 1'b1, "after_reset_rotate");
    apply(4'b0000, 4'b0000, 2'd2, 1'b0, "after_reset_idle");

`ifdef ARB_LOCK_EN
    do_reset(4'b0000);
    lock = 1'b1;
    apply(4'b0010, 4'b0010, 2'd1, 1'b1, "lock_first");
    for (int k = 0; k < 10; k++)
      apply(4'b0011, 4'b0010, 2'd1, 1'b1, $sformatf("lock_hold_c%0d", k));
    lock = 1'b0;
    apply(4'b0011, 4'b0001, 2'd0, 1'b1, "lock_release");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
